// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite renderer.
//   - game state encoding (TITLE..FAIL)
//   - play-field dimensions (320x240, shown 2x on a 640x480 raster)
//   - is_stage(): states in which sprites are drawn
package sprite_pkg;

  typedef enum logic [3:0] {
    TITLE  = 4'd0,
    INTRO1 = 4'd1,
    STAGE1 = 4'd2,
    INTRO2 = 4'd3,
    STAGE2 = 4'd4,
    INTRO3 = 4'd5,
    STAGE3 = 4'd6,
    WIN    = 4'd7,
    FAIL   = 4'd8
  } game_state_e;

  localparam int FIELD_W = 320;
  localparam int FIELD_H = 240;

  function automatic logic is_stage(input logic [3:0] state);
    return (state == STAGE1) || (state == STAGE2) || (state == STAGE3);
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// sprite_anim_ctr: per-sprite animation timing.
//   clk, rst          pixel clock, async active-high reset
//   frame_start       one-cycle pulse at start of vertical blank
//   en_new, row_new   enable/row being latched on this frame_start
//   row_old           row currently held in the shadow register
//   frame_idx         current animation frame (0..N_FRAMES-1)
// tick_cnt counts frame_start pulses; every FRAME_TICKS pulses the frame
// advances. A row change restarts the animation; disabled sprites sit at 0.
module sprite_anim_ctr #(
  parameter int N_FRAMES    = 4,
  parameter int FRAME_TICKS = 6,
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          en_new,
  input  logic [3:0]    row_new,
  input  logic [3:0]    row_old,
  output logic [FW-1:0] frame_idx
);

  logic [5:0] tick_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      frame_idx <= '0;
    end else if (frame_start) begin
      // restart wins over advance
      if (!en_new || (row_new != row_old)) begin
        tick_cnt  <= '0;
        frame_idx <= '0;
      end else if (tick_cnt == 6'(FRAME_TICKS - 1)) begin
        tick_cnt  <= '0;
        frame_idx <= (frame_idx == FW'(N_FRAMES - 1)) ? '0 : frame_idx + FW'(1);
      end else begin
        tick_cnt <= tick_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_anim_engine.sv
// sprite_anim_engine: 2-stage pipelined multi-sprite renderer.
//   clk, rst        pixel clock, async active-high reset
//   frame_start     vblank pulse; latches shadow copies of sprite inputs
//   state           game state; drawing only in STAGE1/2/3
//   h_cnt, v_cnt    VGA raster position (field pixel = count >> 1)
//   spr_en/x/y/row  per-sprite controls (packed, sprite i in slice i)
//   spr_flip        per-sprite horizontal mirror (SPRITE_HFLIP_EN only)
//   pixel_addr      sheet ROM address, 2 cycles after h_cnt/v_cnt
//   is_object       some sprite covers the pixel
//   obj_id          lowest-index sprite covering the pixel
// Build option: define SPRITE_HFLIP_EN to add the spr_flip port.
module sprite_anim_engine
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 10,
  parameter int SPR_H       = 10,
  parameter int N_FRAMES    = 4,
  parameter int N_SPRITES   = 2,
  parameter int SHEET_W     = 320,
  parameter int SHEET_DEPTH = 76800,
  parameter int FRAME_TICKS = 6,
  localparam int IW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [3:0]                state,
  input  logic [9:0]                h_cnt,
  input  logic [9:0]                v_cnt,
  input  logic [N_SPRITES-1:0]      spr_en,
  input  logic [N_SPRITES-1:0][8:0] spr_x,
  input  logic [N_SPRITES-1:0][8:0] spr_y,
  input  logic [N_SPRITES-1:0][3:0] spr_row,
`ifdef SPRITE_HFLIP_EN
  input  logic [N_SPRITES-1:0]      spr_flip,
`endif
  output logic [16:0]               pixel_addr,
  output logic                      is_object,
  output logic [IW-1:0]             obj_id
);

  localparam int STAGES = 2;
  localparam int AW = ($clog2(2 * SHEET_DEPTH) > 17) ? $clog2(2 * SHEET_DEPTH) : 17;
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int DW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

  // ---------------- shadow registers ----------------
  logic [N_SPRITES-1:0]      sh_en;
  logic [N_SPRITES-1:0][8:0] sh_x, sh_y;
  logic [N_SPRITES-1:0][3:0] sh_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_en  <= '0;
      sh_x   <= '0;
      sh_y   <= '0;
      sh_row <= '0;
    end else if (frame_start) begin
      sh_en  <= spr_en;
      sh_x   <= spr_x;
      sh_y   <= spr_y;
      sh_row <= spr_row;
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic [N_SPRITES-1:0] sh_flip;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sh_flip <= '0;
    else if (frame_start) sh_flip <= spr_flip;
  end
`endif

  // ---------------- stage 1: per-sprite hit + offsets ----------------
  logic [9:0] x10, y10;
  logic       vld_in;
  assign x10    = {1'b0, h_cnt[9:1]};
  assign y10    = {1'b0, v_cnt[9:1]};
  assign vld_in = (h_cnt < 10'(2 * FIELD_W)) && (v_cnt < 10'(2 * FIELD_H)) && is_stage(state);

  logic [N_SPRITES-1:0][FW-1:0] frame_idx;
  logic [N_SPRITES-1:0]         hit_c;
  logic [N_SPRITES-1:0][CW-1:0] col_c;
  logic [N_SPRITES-1:0][DW-1:0] dy_c;
  logic [N_SPRITES-1:0][AW-1:0] base_c;

  for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_spr
    logic [9:0] sx, sy;
    assign sx = {1'b0, sh_x[gi]};
    assign sy = {1'b0, sh_y[gi]};

    sprite_anim_ctr #(
      .N_FRAMES   (N_FRAMES),
      .FRAME_TICKS(FRAME_TICKS)
    ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .en_new     (spr_en[gi]),
      .row_new    (spr_row[gi]),
      .row_old    (sh_row[gi]),
      .frame_idx  (frame_idx[gi])
    );

    // 10-bit compares so sx+SPR_W never wraps
    assign hit_c[gi] = sh_en[gi] && (x10 >= sx) && (x10 < sx + 10'(SPR_W))
                                 && (y10 >= sy) && (y10 < sy + 10'(SPR_H));
    // offsets only meaningful on a hit, so truncation is safe
    assign dy_c[gi] = DW'(y10 - sy);
`ifdef SPRITE_HFLIP_EN
    assign col_c[gi] = sh_flip[gi] ? CW'(SPR_W - 1) - CW'(x10 - sx) : CW'(x10 - sx);
`else
    assign col_c[gi] = CW'(x10 - sx);
`endif
    // frame/row base captured here so a frame_start cannot skew in-flight pixels
    assign base_c[gi] = AW'(frame_idx[gi]) * AW'(SPR_W)
                      + AW'(sh_row[gi]) * AW'(SPR_H * SHEET_W);
  end

  logic [STAGES:1]              vld_pipe;
  logic [N_SPRITES-1:0]         s1_hit;
  logic [N_SPRITES-1:0][CW-1:0] s1_col;
  logic [N_SPRITES-1:0][DW-1:0] s1_dy;
  logic [N_SPRITES-1:0][AW-1:0] s1_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      s1_hit      <= '0;
      s1_col      <= '0;
      s1_dy       <= '0;
      s1_base     <= '0;
    end else begin
      vld_pipe[1] <= vld_in;
      s1_hit      <= hit_c;
      s1_col      <= col_c;
      s1_dy       <= dy_c;
      s1_base     <= base_c;
    end
  end

  // ---------------- stage 2: priority select + address ----------------
  logic          win_hit;
  logic [IW-1:0] win_id;
  logic [CW-1:0] win_col;
  logic [DW-1:0] win_dy;
  logic [AW-1:0] win_base, raw, addr_c;

  always_comb begin
    win_hit  = 1'b0;
    win_id   = '0;
    win_col  = '0;
    win_dy   = '0;
    win_base = '0;
    // walk high-to-low so the lowest index ends up winning
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_hit  = 1'b1;
        win_id   = IW'(i);
        win_col  = s1_col[i];
        win_dy   = s1_dy[i];
        win_base = s1_base[i];
      end
    end
    raw    = AW'(win_dy) * AW'(SHEET_W) + AW'(win_col) + win_base;
    addr_c = (raw >= AW'(SHEET_DEPTH)) ? raw - AW'(SHEET_DEPTH) : raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      pixel_addr  <= '0;
      obj_id      <= '0;
    end else if (vld_pipe[1] && win_hit) begin
      vld_pipe[2] <= 1'b1;
      pixel_addr  <= 17'(addr_c);
      obj_id      <= win_id;
    end else begin
      vld_pipe[2] <= 1'b0;
      pixel_addr  <= '0;
      obj_id      <= '0;
    end
  end

  assign is_object = vld_pipe[STAGES];

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Directed bench for sprite_anim_engine (default parameters).
module tb_sprite_anim_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [3:0]  state = 4'd2;
  logic [9:0]  h_cnt = '0, v_cnt = '0;
  logic [1:0]  spr_en = '0;
  logic [1:0][8:0] spr_x = '0, spr_y = '0;
  logic [1:0][3:0] spr_row = '0;
`ifdef SPRITE_HFLIP_EN
  logic [1:0]  spr_flip = '0;
`endif
  logic [16:0] pixel_addr;
  logic        is_object;
  logic [0:0]  obj_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sprite_anim_engine dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .state      (state),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .spr_en     (spr_en),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_row    (spr_row),
`ifdef SPRITE_HFLIP_EN
    .spr_flip   (spr_flip),
`endif
    .pixel_addr (pixel_addr),
    .is_object  (is_object),
    .obj_id     (obj_id)
  );

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
    end
  endtask

  // present a pixel and wait out the 2-cycle latency
  task automatic probe(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk); h_cnt = h; v_cnt = v;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    spr_en = 2'b01; spr_x[0] = 9'd100; spr_y[0] = 9'd50; spr_row[0] = 4'd0;
    h_cnt = 10'd206; v_cnt = 10'd104;
    repeat (2) @(negedge clk);
    checks++; if (is_object !== 1'b0) begin errors++; $display("FAIL reset_is_object got=%0b exp=0", is_object); end
    checks++; if (pixel_addr !== 17'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", pixel_addr); end
    checks++; if (obj_id !== 1'b0) begin errors++; $display("FAIL reset_obj_id got=%0d exp=0", obj_id); end
    @(negedge clk); rst = 1'b0;
    // nothing draws before the first frame_start latches the shadows
    probe(10'd206, 10'd104);
    checks++; if (is_object !== 1'b0) begin errors++; $display("FAIL pre_frame_hit got=%0b exp=0", is_object); end
  endtask

  task automatic test_static_hit();
    pulse(1);
    probe(10'd206, 10'd104);
    checks++; if (is_object !== 1'b1) begin errors++; $display("FAIL static_is_object got=%0b exp=1", is_object); end
    checks++; if (obj_id !== 1'b0) begin errors++; $display("FAIL static_obj_id got=%0d exp=0", obj_id); end
    checks++; if (pixel_addr !== 17'd643) begin errors++; $display("FAIL static_addr got=%0d exp=643", pixel_addr); end
    // live input change without frame_start must be invisible
    spr_x[0] = 9'd0;
    probe(10'd206, 10'd104);
    checks++; if (pixel_addr !== 17'd643) begin errors++; $display("FAIL shadow_hold got=%0d exp=643", pixel_addr); end
    spr_x[0] = 9'd100;
  endtask

  task automatic test_animation();
    do_reset();
    pulse(12);
    probe(10'd206, 10'd104);
    checks++; if (pixel_addr !== 17'd663) begin errors++; $display("FAIL anim_frame2 got=%0d exp=663", pixel_addr); end
    pulse(12);
    probe(10'd206, 10'd104);
    checks++; if (pixel_addr !== 17'd643) begin errors++; $display("FAIL anim_wrap got=%0d exp=643", pixel_addr); end
  endtask

  task automatic test_row_change();
    do_reset();
    pulse(18);
    probe(10'd206, 10'd104);
    checks++; if (pixel_addr !== 17'd673) begin errors++; $display("FAIL row_pre_frame3 got=%0d exp=673", pixel_addr); end
    spr_row[0] = 4'd1;
    pulse(1);
    probe(10'd200, 10'd100);
    checks++; if (pixel_addr !== 17'd3200) begin errors++; $display("FAIL row_change_addr got=%0d exp=3200", pixel_addr); end
  endtask

  task automatic test_overlap();
    do_reset();
    spr_x[0] = 9'd10; spr_y[0] = 9'd10; spr_row[0] = 4'd0;
    spr_x[1] = 9'd10; spr_y[1] = 9'd10; spr_row[1] = 4'd2;
    spr_en = 2'b11;
    pulse(1);
    probe(10'd26, 10'd24);
    checks++; if (obj_id !== 1'b0) begin errors++; $display("FAIL overlap_obj0 got=%0d exp=0", obj_id); end
    checks++; if (pixel_addr !== 17'd643) begin errors++; $display("FAIL overlap_addr0 got=%0d exp=643", pixel_addr); end
    spr_en = 2'b10;
    pulse(1);
    probe(10'd26, 10'd24);
    checks++; if (obj_id !== 1'b1 || is_object !== 1'b1) begin errors++; $display("FAIL overlap_obj1 got=%0d/%0b exp=1/1", obj_id, is_object); end
    checks++; if (pixel_addr !== 17'd7043) begin errors++; $display("FAIL overlap_addr1 got=%0d exp=7043", pixel_addr); end
  endtask

  task automatic test_gating();
    state = 4'd0;
    probe(10'd26, 10'd24);
    checks++; if (is_object !== 1'b0 || pixel_addr !== 17'd0) begin errors++; $display("FAIL gate_title got=%0b/%0d exp=0/0", is_object, pixel_addr); end
    state = 4'd6;
    probe(10'd40, 10'd24);
    checks++; if (is_object !== 1'b0) begin errors++; $display("FAIL edge_x_end got=%0b exp=0", is_object); end
    probe(10'd38, 10'd24);
    checks++; if (is_object !== 1'b1 || obj_id !== 1'b1) begin errors++; $display("FAIL edge_x_last got=%0b/%0d exp=1/1", is_object, obj_id); end
    spr_x[1] = 9'd315;
    pulse(1);
    probe(10'd640, 10'd24);
    checks++; if (is_object !== 1'b0) begin errors++; $display("FAIL edge_h640 got=%0b exp=0", is_object); end
    probe(10'd638, 10'd24);
    checks++; if (is_object !== 1'b1) begin errors++; $display("FAIL edge_h638 got=%0b exp=1", is_object); end
  endtask

  task automatic test_reset_mid();
    probe(10'd638, 10'd24);
    checks++; if (is_object !== 1'b1) begin errors++; $display("FAIL mid_pre_hit got=%0b exp=1", is_object); end
    rst = 1'b1;
    #1;
    checks++; if (is_object !== 1'b0) begin errors++; $display("FAIL mid_rst_is_object got=%0b exp=0", is_object); end
    checks++; if (pixel_addr !== 17'd0) begin errors++; $display("FAIL mid_rst_addr got=%0d exp=0", pixel_addr); end
    checks++; if (obj_id !== 1'b0) begin errors++; $display("FAIL mid_rst_obj_id got=%0d exp=0", obj_id); end
    @(negedge clk); rst = 1'b0;
  endtask

`ifdef SPRITE_HFLIP_EN
  task automatic test_flip();
    do_reset();
    spr_en = 2'b01; spr_x[0] = 9'd100; spr_y[0] = 9'd50; spr_row[0] = 4'd0;
    spr_flip = 2'b01;
    pulse(1);
    probe(10'd200, 10'd100);
    checks++; if (pixel_addr !== 17'd9) begin errors++; $display("FAIL flip_addr got=%0d exp=9", pixel_addr); end
  endtask
`endif

  initial begin
    test_reset();
    test_static_hit();
    test_animation();
    test_row_change();
    test_overlap();
    test_gating();
    test_reset_mid();
`ifdef SPRITE_HFLIP_EN
    test_flip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
